// File: rtl/rob_commit_pkg.sv
// Shared types and constants for the reorder-buffer commit block.
package rob_commit_pkg;
    localparam int ROB_WIDTH_DEFAULT = 6;
    localparam logic [5:0] REG_ZERO = 6'd0;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic [5:0]  write_register;
        logic        reg_dest;
        logic [31:0] value;
    } rob_entry_t;
endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/count bookkeeping for the ROB plus full/empty/ready decode.
module rob_ptr_ctrl
    import rob_commit_pkg::*;
#(
    parameter int ROBWIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                FREEZE,
    input  logic                FLUSH,
    input  logic                alloc_valid,
    input  logic                commit_fire,
    output logic [ROBWIDTH-1:0] head,
    output logic [ROBWIDTH-1:0] tail,
    output logic [ROBWIDTH:0]   count,
    output logic                full,
    output logic                empty,
    output logic                ready,
    output logic                alloc_fire
);
    localparam logic [ROBWIDTH:0] FULL_COUNT = {1'b1, {ROBWIDTH{1'b0}}};

    // alloc_valid/alloc_ready: an entry is taken on a rising edge where both
    // are high and neither FLUSH nor FREEZE is set; dispatch may hold valid while
    // ready is low, and ready never depends on a same-cycle commit.
    assign full       = (count == FULL_COUNT);
    assign empty      = (count == '0);
    assign ready      = !full;
    assign alloc_fire = alloc_valid && ready && !FLUSH && !FREEZE;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (FLUSH) begin
            tail  <= head;
            count <= '0;
        end else if (!FREEZE) begin
            if (alloc_fire)
                tail <= tail + 1'b1;
            if (commit_fire)
                head <= head + 1'b1;
            case ({alloc_fire, commit_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/rob_commit.sv
// In-order commit stage: allocates entries, absorbs completions, retires one
// entry per cycle onto the commit forwarding bus.
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int ROBWIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                FREEZE,
    input  logic                FLUSH,
    input  logic                alloc_valid,
    input  logic [5:0]          alloc_writeRegister,
    input  logic                alloc_RegDest,
    output logic                alloc_ready,
    output logic [ROBWIDTH-1:0] ROB_tail_pointer,
    input  logic                complete_valid,
    input  logic [ROBWIDTH-1:0] complete_ptr,
    input  logic [31:0]         complete_value,
    output logic [31:0]         fwd_data_1_COM,
    output logic [5:0]          fwd_reg_1_COM,
    output logic                fwd_data_1_COM_flag,
    output logic [ROBWIDTH-1:0] ROB_head_pointer,
    output logic [ROBWIDTH:0]   rob_count,
    output logic                rob_empty,
    output logic                rob_full
);
    localparam int DEPTH = 1 << ROBWIDTH;

    rob_entry_t entries [DEPTH];

    logic alloc_fire;
    logic commit_fire;
    logic complete_fire;
    rob_entry_t head_entry;

    rob_ptr_ctrl #(.ROBWIDTH(ROBWIDTH)) u_ptr (
        .CLK         (CLK),
        .RESET       (RESET),
        .FREEZE      (FREEZE),
        .FLUSH       (FLUSH),
        .alloc_valid (alloc_valid),
        .commit_fire (commit_fire),
        .head        (ROB_head_pointer),
        .tail        (ROB_tail_pointer),
        .count       (rob_count),
        .full        (rob_full),
        .empty       (rob_empty),
        .ready       (alloc_ready),
        .alloc_fire  (alloc_fire)
    );

    assign head_entry    = entries[ROB_head_pointer];
    assign commit_fire   = !FLUSH && !FREEZE && head_entry.valid && head_entry.done;
    assign complete_fire = complete_valid && !FLUSH && !FREEZE && entries[complete_ptr].valid;

    // Allocation is written last so it wins over an (illegal) same-index completion.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++)
                entries[i] <= '0;
        end else if (FLUSH) begin
            for (int i = 0; i < DEPTH; i++)
                entries[i].valid <= 1'b0;
        end else if (!FREEZE) begin
            if (commit_fire)
                entries[ROB_head_pointer].valid <= 1'b0;
            if (complete_fire) begin
                entries[complete_ptr].value <= complete_value;
                entries[complete_ptr].done  <= 1'b1;
            end
            if (alloc_fire)
                entries[ROB_tail_pointer] <= '{valid: 1'b1, done: 1'b0,
                                               write_register: alloc_writeRegister,
                                               reg_dest: alloc_RegDest, value: 32'd0};
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fwd_data_1_COM      <= '0;
            fwd_reg_1_COM       <= '0;
            fwd_data_1_COM_flag <= 1'b0;
        end else if (commit_fire) begin
            fwd_data_1_COM      <= head_entry.value;
            fwd_reg_1_COM       <= head_entry.write_register;
            fwd_data_1_COM_flag <= head_entry.reg_dest && (head_entry.write_register != REG_ZERO);
        end else begin
            fwd_data_1_COM_flag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: reset, ordering, full, wrap, flush, r0 and freeze.
module tb_rob_commit;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        FREEZE = 1'b0;
    logic        FLUSH = 1'b0;
    logic        alloc_valid = 1'b0;
    logic [5:0]  alloc_writeRegister = '0;
    logic        alloc_RegDest = 1'b0;
    logic        alloc_ready;
    logic [5:0]  ROB_tail_pointer;
    logic        complete_valid = 1'b0;
    logic [5:0]  complete_ptr = '0;
    logic [31:0] complete_value = '0;
    logic [31:0] fwd_data_1_COM;
    logic [5:0]  fwd_reg_1_COM;
    logic        fwd_data_1_COM_flag;
    logic [5:0]  ROB_head_pointer;
    logic [6:0]  rob_count;
    logic        rob_empty;
    logic        rob_full;

    int n_cmp = 0;
    int n_fail = 0;

    rob_commit #(.ROBWIDTH(6)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .FREEZE              (FREEZE),
        .FLUSH               (FLUSH),
        .alloc_valid         (alloc_valid),
        .alloc_writeRegister (alloc_writeRegister),
        .alloc_RegDest       (alloc_RegDest),
        .alloc_ready         (alloc_ready),
        .ROB_tail_pointer    (ROB_tail_pointer),
        .complete_valid      (complete_valid),
        .complete_ptr        (complete_ptr),
        .complete_value      (complete_value),
        .fwd_data_1_COM      (fwd_data_1_COM),
        .fwd_reg_1_COM       (fwd_reg_1_COM),
        .fwd_data_1_COM_flag (fwd_data_1_COM_flag),
        .ROB_head_pointer    (ROB_head_pointer),
        .rob_count           (rob_count),
        .rob_empty           (rob_empty),
        .rob_full            (rob_full)
    );

    always #5 CLK = ~CLK;

    // ---- driver tasks ----
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RESET = 1'b0;
        FREEZE = 1'b0;
        FLUSH = 1'b0;
        alloc_valid = 1'b0;
        complete_valid = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
    endtask

    task automatic drive_alloc(input logic [5:0] r, input logic rd);
        alloc_valid = 1'b1;
        alloc_writeRegister = r;
        alloc_RegDest = rd;
    endtask

    task automatic drive_complete(input logic [5:0] p, input logic [31:0] v);
        complete_valid = 1'b1;
        complete_ptr = p;
        complete_value = v;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        RESET = 1'b0;
        tick();
        n_cmp++; if (ROB_head_pointer !== 6'd0) begin n_fail++; $display("FAIL reset_head got %0d want 0", ROB_head_pointer); end
        n_cmp++; if (ROB_tail_pointer !== 6'd0) begin n_fail++; $display("FAIL reset_tail got %0d want 0", ROB_tail_pointer); end
        n_cmp++; if (rob_count !== 7'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", rob_count); end
        n_cmp++; if (rob_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", rob_empty); end
        n_cmp++; if (rob_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", rob_full); end
        n_cmp++; if (fwd_data_1_COM_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag got %b want 0", fwd_data_1_COM_flag); end
        n_cmp++; if (fwd_data_1_COM !== 32'd0 || fwd_reg_1_COM !== 6'd0) begin n_fail++; $display("FAIL reset_fwd got %h/%0d want 0/0", fwd_data_1_COM, fwd_reg_1_COM); end
        RESET = 1'b1;
    endtask

    task automatic test_in_order();
        logic [5:0] regs [3];
        regs[0] = 6'd5; regs[1] = 6'd6; regs[2] = 6'd7;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive_alloc(regs[i], 1'b1);
            n_cmp++; if (ROB_tail_pointer !== 6'(i)) begin n_fail++; $display("FAIL order_alloc_ptr got %0d want %0d", ROB_tail_pointer, i); end
            tick();
        end
        alloc_valid = 1'b0;
        n_cmp++; if (rob_count !== 7'd3) begin n_fail++; $display("FAIL order_count got %0d want 3", rob_count); end
        drive_complete(6'd2, 32'h33);
        tick();
        drive_complete(6'd0, 32'h11);
        tick();
        n_cmp++; if (fwd_data_1_COM_flag !== 1'b0) begin n_fail++; $display("FAIL order_no_bypass flag got %b want 0", fwd_data_1_COM_flag); end
        drive_complete(6'd1, 32'h22);
        tick();
        n_cmp++; if (fwd_data_1_COM_flag !== 1'b1 || fwd_reg_1_COM !== 6'd5 || fwd_data_1_COM !== 32'h11) begin n_fail++; $display("FAIL order_c0 got %b/%0d/%h want 1/5/11", fwd_data_1_COM_flag, fwd_reg_1_COM, fwd_data_1_COM); end
        complete_valid = 1'b0;
        tick();
        n_cmp++; if (fwd_data_1_COM_flag !== 1'b1 || fwd_reg_1_COM !== 6'd6 || fwd_data_1_COM !== 32'h22) begin n_fail++; $display("FAIL order_c1 got %b/%0d/%h want 1/6/22", fwd_data_1_COM_flag, fwd_reg_1_COM, fwd_data_1_COM); end
        tick();
        n_cmp++; if (fwd_data_1_COM_flag !== 1'b1 || fwd_reg_1_COM !== 6'd7 || fwd_data_1_COM !== 32'h33) begin n_fail++; $display("FAIL order_c2 got %b/%0d/%h want 1/7/33", fwd_data_1_COM_flag, fwd_reg_1_COM, fwd_data_1_COM); end
        tick();
        n_cmp++; if (fwd_data_1_COM_flag !== 1'b0) begin n_fail++; $display("FAIL order_flag_drop got %b want 0", fwd_data_1_COM_flag); end
        n_cmp++; if (rob_empty !== 1'b1 || ROB_head_pointer !== 6'd3) begin n_fail++; $display("FAIL order_end got empty=%b head=%0d want 1/3", rob_empty, ROB_head_pointer); end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 64; i++) begin
            drive_alloc(6'(i), 1'b1);
            tick();
        end
        n_cmp++; if (rob_full !== 1'b1 || alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_flags got full=%b ready=%b want 1/0", rob_full, alloc_ready); end
        n_cmp++; if (rob_count !== 7'd64) begin n_fail++; $display("FAIL full_count got %0d want 64", rob_count); end
        tick();
        alloc_valid = 1'b0;
        n_cmp++; if (ROB_tail_pointer !== 6'd0 || rob_count !== 7'd64) begin n_fail++; $display("FAIL full_65th got tail=%0d count=%0d want 0/64", ROB_tail_pointer, rob_count); end
        n_cmp++; if (rob_empty !== 1'b0) begin n_fail++; $display("FAIL full_empty got %b want 0", rob_empty); end
        // Asynchronous reset: checked before any clock edge.
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        n_cmp++; if (rob_count !== 7'd0 || rob_empty !== 1'b1 || rob_full !== 1'b0) begin n_fail++; $display("FAIL async_reset got count=%0d empty=%b full=%b want 0/1/0", rob_count, rob_empty, rob_full); end
        tick();
        RESET = 1'b1;
    endtask

    task automatic test_wrap();
        logic [5:0] tails [5];
        tails[0] = 6'd62; tails[1] = 6'd63; tails[2] = 6'd0; tails[3] = 6'd1; tails[4] = 6'd2;
        apply_reset();
        for (int i = 0; i < 62; i++) begin
            drive_alloc(6'd1, 1'b0);
            tick();
        end
        alloc_valid = 1'b0;
        for (int i = 0; i < 62; i++) begin
            drive_complete(6'(i), 32'(i));
            tick();
        end
        complete_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if (ROB_head_pointer !== 6'd62 || ROB_tail_pointer !== 6'd62 || rob_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_setup got head=%0d tail=%0d empty=%b want 62/62/1", ROB_head_pointer, ROB_tail_pointer, rob_empty); end
        for (int i = 0; i < 4; i++) begin
            drive_alloc(6'(10 + i), 1'b1);
            n_cmp++; if (ROB_tail_pointer !== tails[i]) begin n_fail++; $display("FAIL wrap_tail got %0d want %0d", ROB_tail_pointer, tails[i]); end
            tick();
        end
        alloc_valid = 1'b0;
        n_cmp++; if (ROB_tail_pointer !== tails[4]) begin n_fail++; $display("FAIL wrap_tail_end got %0d want %0d", ROB_tail_pointer, tails[4]); end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive_complete(tails[i], 32'hA0 + 32'(i));
            else complete_valid = 1'b0;
            tick();
            if (i > 0) begin
                n_cmp++;
                if (fwd_data_1_COM_flag !== 1'b1 || fwd_reg_1_COM !== 6'(9 + i) || fwd_data_1_COM !== 32'h9F + 32'(i)) begin
                    n_fail++;
                    $display("FAIL wrap_commit%0d got %b/%0d/%h want 1/%0d/%h", i, fwd_data_1_COM_flag, fwd_reg_1_COM, fwd_data_1_COM, 9 + i, 32'h9F + 32'(i));
                end
            end
        end
        tick();
        n_cmp++; if (rob_empty !== 1'b1 || ROB_head_pointer !== 6'd2) begin n_fail++; $display("FAIL wrap_end got empty=%b head=%0d want 1/2", rob_empty, ROB_head_pointer); end
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive_alloc(6'(i + 1), 1'b1);
            tick();
        end
        alloc_valid = 1'b0;
        drive_complete(6'd0, 32'h55);
        tick();
        complete_valid = 1'b0;
        FLUSH = 1'b1;
        drive_alloc(6'd20, 1'b1);
        tick();
        FLUSH = 1'b0;
        alloc_valid = 1'b0;
        n_cmp++; if (rob_count !== 7'd0 || ROB_tail_pointer !== ROB_head_pointer || ROB_head_pointer !== 6'd0) begin n_fail++; $display("FAIL flush_ptrs got count=%0d head=%0d tail=%0d want 0/0/0", rob_count, ROB_head_pointer, ROB_tail_pointer); end
        n_cmp++; if (fwd_data_1_COM_flag !== 1'b0) begin n_fail++; $display("FAIL flush_flag got %b want 0", fwd_data_1_COM_flag); end
        drive_complete(6'd3, 32'h99);
        tick();
        complete_valid = 1'b0;
        tick();
        n_cmp++; if (fwd_data_1_COM_flag !== 1'b0 || rob_count !== 7'd0) begin n_fail++; $display("FAIL flush_stale_complete got flag=%b count=%0d want 0/0", fwd_data_1_COM_flag, rob_count); end
        drive_alloc(6'd9, 1'b1);
        tick();
        alloc_valid = 1'b0;
        tick();
        n_cmp++; if (fwd_data_1_COM_flag !== 1'b0 || rob_count !== 7'd1) begin n_fail++; $display("FAIL flush_realloc_not_done got flag=%b count=%0d want 0/1", fwd_data_1_COM_flag, rob_count); end
        drive_complete(6'd0, 32'h77);
        tick();
        complete_valid = 1'b0;
        tick();
        n_cmp++; if (fwd_data_1_COM_flag !== 1'b1 || fwd_reg_1_COM !== 6'd9 || fwd_data_1_COM !== 32'h77) begin n_fail++; $display("FAIL flush_realloc_commit got %b/%0d/%h want 1/9/77", fwd_data_1_COM_flag, fwd_reg_1_COM, fwd_data_1_COM); end
    endtask

    task automatic test_r0_freeze();
        apply_reset();
        drive_alloc(6'd0, 1'b1);
        tick();
        drive_alloc(6'd4, 1'b0);
        tick();
        drive_alloc(6'd8, 1'b1);
        tick();
        alloc_valid = 1'b0;
        drive_complete(6'd0, 32'h10);
        tick();
        drive_complete(6'd1, 32'h20);
        tick();
        n_cmp++; if (fwd_data_1_COM_flag !== 1'b0 || ROB_head_pointer !== 6'd1 || fwd_data_1_COM !== 32'h10) begin n_fail++; $display("FAIL r0_commit got flag=%b head=%0d data=%h want 0/1/10", fwd_data_1_COM_flag, ROB_head_pointer, fwd_data_1_COM); end
        drive_complete(6'd2, 32'h30);
        tick();
        n_cmp++; if (fwd_data_1_COM_flag !== 1'b0 || ROB_head_pointer !== 6'd2 || fwd_reg_1_COM !== 6'd4) begin n_fail++; $display("FAIL nodest_commit got flag=%b head=%0d reg=%0d want 0/2/4", fwd_data_1_COM_flag, ROB_head_pointer, fwd_reg_1_COM); end
        complete_valid = 1'b0;
        FREEZE = 1'b1;
        drive_alloc(6'd12, 1'b1);
        tick();
        tick();
        n_cmp++; if (fwd_data_1_COM_flag !== 1'b0 || ROB_head_pointer !== 6'd2 || fwd_data_1_COM !== 32'h20) begin n_fail++; $display("FAIL freeze_hold got flag=%b head=%0d data=%h want 0/2/20", fwd_data_1_COM_flag, ROB_head_pointer, fwd_data_1_COM); end
        n_cmp++; if (ROB_tail_pointer !== 6'd3 || rob_count !== 7'd1) begin n_fail++; $display("FAIL freeze_alloc got tail=%0d count=%0d want 3/1", ROB_tail_pointer, rob_count); end
        alloc_valid = 1'b0;
        FREEZE = 1'b0;
        tick();
        n_cmp++; if (fwd_data_1_COM_flag !== 1'b1 || fwd_reg_1_COM !== 6'd8 || fwd_data_1_COM !== 32'h30 || ROB_head_pointer !== 6'd3) begin n_fail++; $display("FAIL freeze_release got %b/%0d/%h head=%0d want 1/8/30/3", fwd_data_1_COM_flag, fwd_reg_1_COM, fwd_data_1_COM, ROB_head_pointer); end
        tick();
        n_cmp++; if (fwd_data_1_COM_flag !== 1'b0 || rob_empty !== 1'b1) begin n_fail++; $display("FAIL freeze_end got flag=%b empty=%b want 0/1", fwd_data_1_COM_flag, rob_empty); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full();
        test_wrap();
        test_flush();
        test_r0_freeze();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
